// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit holding the architectural HI/LO
// registers. MULT/MULTU/DIV/DIVU take WIDTH shift-add or restoring
// subtract-shift steps on magnitudes, followed by one sign-fix/write cycle.
// MTHI/MTLO complete in a single cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rsData,
    input  logic [WIDTH-1:0] rtData,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc_hi;   // partial product high half / running remainder
    logic [WIDTH-1:0] acc_lo;   // multiplier bits shifting out / quotient bits shifting in
    logic [WIDTH-1:0] opb;      // |multiplicand| or |divisor|
    logic [WIDTH-1:0] a_orig;   // raw dividend, returned as HI on divide by zero
    logic             is_div;
    logic             neg_q;    // product / quotient must be negated
    logic             neg_r;    // remainder must be negated (sign of dividend)
    logic             b_zero;

    logic             start_md;
    logic             start_mt;
    logic             sgn_op;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [2*WIDTH-1:0] fix_prod;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    // Magnitude of an operand; unsigned ops pass straight through.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                                 input logic sgn);
        logic signed [WIDTH-1:0] sv;
        sv = v;
        return (sgn && sv < 0) ? -v : v;
    endfunction

    // Conditional two's-complement negation for single-width results.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic neg);
        return neg ? -v : v;
    endfunction

    // Conditional two's-complement negation for the double-width product.
    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v,
                                                     input logic neg);
        return neg ? -v : v;
    endfunction

    // A flush in the same cycle as start suppresses the start.
    assign start_md = start && !flush && (state == S_IDLE) && !op[2];
    assign start_mt = start && !flush && (state == S_IDLE) && (op[2:1] == 2'b10);
    assign sgn_op   = !op[0];
    assign busy     = (state != S_IDLE);

    // One iteration step: shift-add for multiply, restoring subtract-shift for divide.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb};
        step_hi   = mul_sum[WIDTH:1];
        step_lo   = {mul_sum[0], acc_lo[WIDTH-1:1]};
        if (is_div) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Sign correction of the finished magnitudes; divide by zero bypasses it.
    always_comb begin
        fix_prod = cond_neg2({acc_hi, acc_lo}, neg_q);
        fix_hi   = fix_prod[2*WIDTH-1:WIDTH];
        fix_lo   = fix_prod[WIDTH-1:0];
        if (is_div) begin
            if (b_zero) begin
                fix_hi = a_orig;
                fix_lo = '1;
            end else begin
                fix_hi = cond_neg(acc_hi, neg_r);
                fix_lo = cond_neg(acc_lo, neg_q);
            end
        end
    end

    // Sequencer: IDLE -> RUN for WIDTH steps -> FIX -> IDLE, with flush abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            count <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_md) begin
                        state <= S_RUN;
                        count <= CW'(WIDTH);
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state <= S_IDLE;
                        count <= '0;
                    end else begin
                        count <= count - CW'(1);
                        if (count == CW'(1)) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    if (!flush) done <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Operand latch at start and accumulator update while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_hi <= '0;
            acc_lo <= '0;
            opb    <= '0;
            a_orig <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
        end else if (start_md) begin
            acc_hi <= '0;
            acc_lo <= op[1] ? abs_val(rsData, sgn_op) : abs_val(rtData, sgn_op);
            opb    <= op[1] ? abs_val(rtData, sgn_op) : abs_val(rsData, sgn_op);
            a_orig <= rsData;
            is_div <= op[1];
            neg_q  <= sgn_op && (rsData[WIDTH-1] ^ rtData[WIDTH-1]);
            neg_r  <= sgn_op && rsData[WIDTH-1];
            b_zero <= (rtData == '0);
        end else if (state == S_RUN && !flush) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
        end
    end

    // Architectural HI/LO: written only by an unflushed FIX or by MTHI/MTLO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (state == S_FIX && !flush) begin
            hi <= fix_hi;
            lo <= fix_lo;
        end else if (start_mt) begin
            if (op[0]) lo <= rsData;
            else       hi <= rsData;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed vector table, random operations against
// an arithmetic reference model, and hand-written flush/reset/MTxx sequences.
module tb_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_NOP   = 3'd6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rsData = '0;
    logic [31:0] rtData = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs[9];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rsData(rsData), .rtData(rtData), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: results from plain 64-bit / 32-bit arithmetic, returned as {hi, lo}.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint p;
        int q;
        int r;
        case (o)
            OP_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            OP_MULTU: return {32'b0, a} * {32'b0, b};
            OP_DIV: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic drive_start(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; rsData = a; rtData = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Multi-cycle op: checks latency, busy window, single-cycle done, stable HI/LO, result.
    task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input string name, input bit inject);
        int lat;
        int busy_cnt;
        bit unstable;
        lat = 0; busy_cnt = 0; unstable = 0;
        drive_start(o, a, b);
        if (busy) busy_cnt++;
        for (int n = 1; n <= 60; n++) begin
            if (inject && n == 6) begin
                start = 1'b1; op = OP_MTHI; rsData = $urandom;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_cnt++;
            if (hi !== mhi || lo !== mlo) unstable = 1;
        end
        check({name, " latency"}, lat, 33);
        check({name, " busy cycles"}, busy_cnt, 33);
        check({name, " busy at done"}, {31'b0, busy}, 32'd0);
        check({name, " hilo stable while busy"}, {31'b0, unstable}, 32'd0);
        check({name, " hi"}, hi, ehi);
        check({name, " lo"}, lo, elo);
        mhi = ehi; mlo = elo;
        @(posedge clk);
        #1;
        check({name, " done one cycle"}, {31'b0, done}, 32'd0);
    endtask

    task automatic run_mt(input logic [2:0] o, input logic [31:0] a, input string name);
        drive_start(o, a, 32'h0);
        if (o == OP_MTHI) mhi = a;
        else if (o == OP_MTLO) mlo = a;
        check({name, " hi"}, hi, mhi);
        check({name, " lo"}, lo, mlo);
        check({name, " busy"}, {31'b0, busy}, 32'd0);
        check({name, " done"}, {31'b0, done}, 32'd0);
    endtask

    // Start an op, optionally attempt an MTHI at mt_at, flush at flush_at; nothing may be written.
    task automatic flush_seq(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                             input int mt_at, input int flush_at, input string name);
        bit saw_done;
        saw_done = 0;
        drive_start(o, a, b);
        for (int n = 1; n <= flush_at; n++) begin
            if (n == mt_at) begin
                start = 1'b1; op = OP_MTHI; rsData = 32'h0000AAAA;
            end
            if (n == flush_at) begin
                check({name, " busy before flush"}, {31'b0, busy}, 32'd1);
                flush = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) saw_done = 1;
        end
        flush = 1'b0;
        check({name, " busy after flush"}, {31'b0, busy}, 32'd0);
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1;
        end
        check({name, " no done"}, {31'b0, saw_done}, 32'd0);
        check({name, " hi kept"}, hi, mhi);
        check({name, " lo kept"}, lo, mlo);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [63:0] r;
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;

        vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4] = '{OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        vecs[5] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[6] = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[7] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

        // Reset state
        #12;
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 9; i++)
            run_md(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo,
                   $sformatf("vec%0d", i), 1'b0);

        // Random ops against the model, with occasional starts while busy
        for (int i = 0; i < 40; i++) begin
            a = pick_operand();
            b = pick_operand();
            if ($urandom_range(0, 5) == 0) begin
                o = ($urandom_range(0, 1) == 0) ? OP_MTHI : OP_MTLO;
                run_mt(o, a, $sformatf("rnd%0d mt", i));
            end else begin
                o = 3'($urandom_range(0, 3));
                r = model(o, a, b);
                run_md(o, a, b, r[63:32], r[31:0], $sformatf("rnd%0d op%0d", i, o),
                       $urandom_range(0, 2) == 0);
            end
        end

        // MULTU then flushed DIVU with an ignored MTHI mid-run
        run_md(OP_MULTU, 32'd3, 32'd4, 32'h0, 32'hC, "multu 3x4", 1'b0);
        flush_seq(OP_DIVU, 32'd100, 32'd7, 5, 10, "flush divu");
        // Flush coinciding with the FIX cycle wins over the write
        flush_seq(OP_MULTU, 32'd9, 32'd9, 0, 33, "flush at fix");

        // Flush with start in IDLE: start ignored
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = OP_MULTU; rsData = 32'd5; rtData = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check("idle flush+start busy", {31'b0, busy}, 32'd0);

        // No-op encoding
        run_mt(OP_NOP, 32'hDEADBEEF, "nop");

        // MTLO / MTHI in IDLE
        run_mt(OP_MTLO, 32'h12345678, "mtlo");
        @(posedge clk);
        #1;
        check("mtlo busy later", {31'b0, busy}, 32'd0);
        run_mt(OP_MTHI, 32'h0BADF00D, "mthi");

        // Asynchronous reset mid-RUN
        drive_start(OP_MULTU, 32'd5, 32'd7);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrun rst hi", hi, 32'h0);
        check("midrun rst lo", lo, 32'h0);
        check("midrun rst busy", {31'b0, busy}, 32'd0);
        check("midrun rst done", {31'b0, done}, 32'd0);
        mhi = '0; mlo = '0;
        @(negedge clk);
        rst = 1'b0;
        run_md(OP_MULTU, 32'd2, 32'd3, 32'h0, 32'h6, "multu after rst", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
